// File: rtl/btn_irq_pkg.sv
// Shared types and constants for the button PIO interrupt dispatcher.
// Holds the dispatcher state encoding and the PIO register map.
package btn_irq_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        RD_WAIT,
        CLR,
        PUSH
    } state_t;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO only lands when a pop
// frees a slot in the same cycle.
module btn_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents index 0 rather than stale storage.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btn_irq_dispatcher.sv
// Services edge-capture button PIOs over one Avalon-MM master: unmasks all
// sources, then round-robin confirms, clears and queues each pending IRQ.
module btn_irq_dispatcher
    import btn_irq_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int IDX_W      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            src_irq,
    output logic [NUM_SRC-1:0]            pio_chipselect,
    output logic [1:0]                    pio_address,
    output logic                          pio_write_n,
    output logic [31:0]                   pio_writedata,
    input  logic [NUM_SRC*32-1:0]         pio_readdata,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [IDX_W-1:0]              evt_src,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          evt_overflow
);

    localparam logic [IDX_W:0]   NSRC_EXT = (IDX_W+1)'(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_SRC - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   init_idx, init_idx_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gnt, gnt_n;

    logic [NUM_SRC-1:0] cs_d;
    logic [1:0]         addr_d;
    logic               wn_d;
    logic [31:0]        wd_d;

    logic [2*NUM_SRC-1:0] irq_dbl;
    logic [NUM_SRC-1:0]   irq_rot;
    logic [IDX_W-1:0]     grant_off;
    logic [IDX_W:0]       grant_sum;
    logic [IDX_W:0]       rr_inc;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;

    logic [NUM_SRC-1:0]   rd_bit0;
    logic                 unused_rd;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_SRC'(1) << i;
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rd
        assign rd_bit0[i] = pio_readdata[i*32];
    end
    assign unused_rd = ^pio_readdata;

    // Rotate so bit 0 is the rr pointer; lowest set bit is the grant offset.
    always_comb begin
        irq_dbl   = {src_irq, src_irq};
        irq_rot   = NUM_SRC'(irq_dbl >> rr_ptr);
        grant_vld = |src_irq;
        grant_off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (irq_rot[k]) grant_off = IDX_W'(k);
        end
        grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
        if (grant_sum >= NSRC_EXT) grant_sum = grant_sum - NSRC_EXT;
        grant_idx = grant_sum[IDX_W-1:0];
        rr_inc    = {1'b0, grant_idx} + (IDX_W+1)'(1);
        if (rr_inc == NSRC_EXT) rr_inc = '0;
    end

    always_comb begin
        state_n    = state;
        init_idx_n = init_idx;
        rr_ptr_n   = rr_ptr;
        gnt_n      = gnt;
        cs_d       = '0;
        addr_d     = ADDR_DATA;
        wn_d       = 1'b1;
        wd_d       = '0;
        fifo_push  = 1'b0;
        unique case (state)
            INIT: begin
                cs_d   = onehot(init_idx);
                addr_d = ADDR_IRQ_MASK;
                wn_d   = 1'b0;
                wd_d   = 32'd1;
                if (init_idx == LAST_SRC) state_n = IDLE;
                else init_idx_n = init_idx + IDX_W'(1);
            end
            IDLE: begin
                if (enable && grant_vld) begin
                    gnt_n    = grant_idx;
                    rr_ptr_n = rr_inc[IDX_W-1:0];
                    cs_d     = onehot(grant_idx);
                    addr_d   = ADDR_EDGE_CAP;
                    state_n  = RD;
                end
            end
            RD: state_n = RD_WAIT;
            RD_WAIT: begin
                if (rd_bit0[gnt]) begin
                    cs_d    = onehot(gnt);
                    addr_d  = ADDR_EDGE_CAP;
                    wn_d    = 1'b0;
                    state_n = CLR;
                end else begin
                    state_n = IDLE;
                end
            end
            CLR: state_n = PUSH;
            PUSH: begin
                fifo_push = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = INIT;
        endcase
    end

    // Bus outputs are registered, so each state's access is visible the cycle it is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            init_idx       <= '0;
            rr_ptr         <= '0;
            gnt            <= '0;
            pio_chipselect <= '0;
            pio_address    <= ADDR_DATA;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            evt_overflow   <= 1'b0;
        end else begin
            state          <= state_n;
            init_idx       <= init_idx_n;
            rr_ptr         <= rr_ptr_n;
            gnt            <= gnt_n;
            pio_chipselect <= cs_d;
            pio_address    <= addr_d;
            pio_write_n    <= wn_d;
            pio_writedata  <= wd_d;
            if (fifo_push && fifo_full && !evt_ready) evt_overflow <= 1'b1;
        end
    end

    btn_evt_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (gnt),
        .pop       (evt_ready),
        .head      (evt_src),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (evt_count)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_btn_irq_dispatcher.sv
// Bench for btn_irq_dispatcher: PIO slave model, transaction-timeline
// reference model checked every cycle, plus directed literal checks.
module tb_btn_irq_dispatcher;

    localparam int NS = 4;
    localparam int IW = 2;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              evt_ready = 1'b0;
    logic [NS-1:0]     src_irq;
    logic [NS-1:0]     pio_chipselect;
    logic [1:0]        pio_address;
    logic              pio_write_n;
    logic [31:0]       pio_writedata;
    logic [NS*32-1:0]  pio_readdata;
    logic              evt_valid;
    logic [IW-1:0]     evt_src;
    logic [3:0]        evt_count;
    logic              evt_overflow;

    always #5 clk = ~clk;

    btn_irq_dispatcher #(.NUM_SRC(NS), .IDX_W(IW), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .src_irq        (src_irq),
        .pio_chipselect (pio_chipselect),
        .pio_address    (pio_address),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_src        (evt_src),
        .evt_count      (evt_count),
        .evt_overflow   (evt_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, got, exp);
        end
    endtask

    // PIO slaves: edge capture, irq mask, registered readdata, clear-over-capture.
    logic [NS-1:0] fire = '0, hold = '0, kill = '0, confirm = '1;
    logic [NS-1:0] irq_q = '0, mask_q = '0, rd_q = '0;

    assign src_irq = irq_q & mask_q;

    always_comb begin
        pio_readdata = '0;
        for (int i = 0; i < NS; i++) pio_readdata[i*32] = rd_q[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            rd_q[i] <= (pio_chipselect[i] && pio_address == 2'd3 && pio_write_n) ? confirm[i] : 1'b0;
            if (pio_chipselect[i] && pio_address == 2'd2 && !pio_write_n)
                mask_q[i] <= pio_writedata[0];
            if (kill[i])
                irq_q[i] <= 1'b0;
            else if (pio_chipselect[i] && pio_address == 2'd3 && !pio_write_n && !hold[i])
                irq_q[i] <= 1'b0;
            else if (fire[i])
                irq_q[i] <= 1'b1;
        end
    end

    // Reference model: timeline in cycles since a grant, plus a queue of events.
    bit            started = 0;
    int            init_k = 0;
    bit            m_ready = 0;
    int            age = 0;
    int            m_g = 0;
    int            m_rr = 0;
    bit            m_ovf = 0;
    int            q[$];
    logic [NS-1:0] e_cs = '0;
    logic [1:0]    e_addr = 2'd0;
    logic          e_wn = 1'b1;
    logic [31:0]   e_wd = '0;

    initial forever begin
        int  old_sz;
        bit  pop;
        bit  found;
        @(posedge clk);
        e_cs = '0; e_addr = 2'd0; e_wn = 1'b1; e_wd = '0;
        if (reset) begin
            started = 1; init_k = 0; m_ready = 0; age = 0; m_rr = 0;
            m_ovf = 0; q.delete();
        end else if (started) begin
            old_sz = q.size();
            pop = evt_ready && (old_sz > 0);
            if (init_k < NS) begin
                e_cs = NS'(1) << init_k; e_addr = 2'd2; e_wn = 1'b0; e_wd = 32'd1;
                init_k++;
                if (init_k == NS) m_ready = 1;
            end else if (m_ready) begin
                if (enable && src_irq != '0) begin
                    found = 0;
                    for (int k = 0; k < NS; k++) begin
                        if (!found && src_irq[(m_rr + k) % NS]) begin
                            found = 1; m_g = (m_rr + k) % NS;
                        end
                    end
                    m_rr = (m_g + 1) % NS;
                    m_ready = 0; age = 1;
                    e_cs = NS'(1) << m_g; e_addr = 2'd3;
                end
            end else begin
                age++;
                if (age == 3) begin
                    if (confirm[m_g]) begin
                        e_cs = NS'(1) << m_g; e_addr = 2'd3; e_wn = 1'b0;
                    end else begin
                        m_ready = 1;
                    end
                end else if (age == 5) begin
                    if (old_sz == FD && !pop) m_ovf = 1;
                    else q.push_back(m_g);
                    m_ready = 1;
                end
            end
            if (pop) void'(q.pop_front());
        end
    end

    initial forever begin
        int exp_src;
        @(negedge clk);
        if (started) begin
            exp_src = (q.size() > 0) ? q[0] : 0;
            check("bus", {pio_chipselect, pio_address, pio_write_n, pio_writedata},
                  {e_cs, e_addr, e_wn, e_wd});
            check("evt", {evt_valid, evt_count, evt_src, evt_overflow},
                  {q.size() > 0, 4'(q.size()), IW'(exp_src), m_ovf});
        end
    end

    bit            log_en = 0;
    logic [NS-1:0] glog[$];

    initial forever begin
        @(negedge clk);
        if (log_en && pio_chipselect != '0 && pio_address == 2'd3 && pio_write_n)
            glog.push_back(pio_chipselect);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            budget;
        int            exp_order[6] = '{1, 2, 8, 1, 2, 8};
        int            ovf_list[9]  = '{0, 1, 2, 3, 1, 0, 3, 2, 1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            check("init_cs", pio_chipselect, NS'(1) << i);
            check("init_wr", {pio_address, pio_write_n, pio_writedata}, {2'd2, 1'b0, 32'd1});
        end
        repeat (2) @(negedge clk);
        check("idle_bus", {pio_chipselect, pio_write_n, evt_valid}, {4'b0000, 1'b1, 1'b0});
        check("mask_set", mask_q, 4'b1111);

        // Round robin with 0,1,3 held pending.
        enable = 1'b1; evt_ready = 1'b1; log_en = 1;
        hold = 4'b1011; fire = 4'b1011;
        @(negedge clk);
        fire = '0;
        budget = 0;
        while (glog.size() < 6 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        hold = '0; log_en = 0;
        check("rr_seen", glog.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) check("rr_order", glog[i], exp_order[i]);
        repeat (40) @(negedge clk);
        check("rr_done", {src_irq, evt_valid}, '0);

        // Single irq on source 2: latency.
        evt_ready = 1'b0;
        fire = 4'b0100;
        @(negedge clk);
        fire = '0;
        @(negedge clk);
        check("lat_rd", {pio_chipselect, pio_address, pio_write_n}, {4'b0100, 2'd3, 1'b1});
        repeat (2) @(negedge clk);
        check("lat_clr", {pio_chipselect, pio_address, pio_write_n, pio_writedata},
              {4'b0100, 2'd3, 1'b0, 32'd0});
        @(negedge clk);
        check("lat_t4", evt_valid, 1'b0);
        @(negedge clk);
        check("lat_evt", {evt_valid, evt_src, evt_count}, {1'b1, 2'd2, 4'd1});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("pop", evt_count, 4'd0);

        // Nine confirmed events into a stalled FIFO.
        for (int k = 0; k < 9; k++) begin
            fire = NS'(1) << ovf_list[k];
            @(negedge clk);
            fire = '0;
            repeat (6) @(negedge clk);
        end
        check("ovf_state", {evt_count, evt_overflow, evt_valid}, {4'd8, 1'b1, 1'b1});
        check("ovf_cleared", src_irq, 4'b0000);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain", evt_src, ovf_list[i]);
            @(negedge clk);
        end
        evt_ready = 1'b0;
        check("drained", {evt_valid, evt_count, evt_overflow}, {1'b0, 4'd0, 1'b1});

        // Spurious irq on source 3.
        confirm = 4'b0111;
        fire = 4'b1000;
        @(negedge clk);
        fire = '0;
        @(negedge clk);
        check("spu_rd", {pio_chipselect, pio_address, pio_write_n}, {4'b1000, 2'd3, 1'b1});
        repeat (2) @(negedge clk);
        check("spu_noclr", {pio_chipselect, pio_write_n}, {4'b0000, 1'b1});
        @(negedge clk);
        check("spu_regrant", {pio_chipselect, pio_address, pio_write_n}, {4'b1000, 2'd3, 1'b1});
        enable = 1'b0; kill = 4'b1000;
        @(negedge clk);
        kill = '0;
        repeat (6) @(negedge clk);
        check("spu_nopush", {evt_count, src_irq}, '0);
        confirm = '1; enable = 1'b1;

        // Leave one event queued, then reset during a clear write.
        fire = 4'b0010;
        @(negedge clk);
        fire = '0;
        repeat (6) @(negedge clk);
        check("pre_rst", {evt_count, evt_src}, {4'd1, 2'd1});
        fire = 4'b0001;
        @(negedge clk);
        fire = '0;
        repeat (3) @(negedge clk);
        check("rst_at_clr", {pio_chipselect, pio_write_n}, {4'b0001, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        check("rst_vals", {pio_chipselect, pio_address, pio_write_n, pio_writedata,
                           evt_valid, evt_src, evt_count, evt_overflow},
              {4'b0000, 2'd0, 1'b1, 32'd0, 1'b0, 2'd0, 4'd0, 1'b0});
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            check("reinit_cs", pio_chipselect, NS'(1) << i);
            check("reinit_wr", {pio_address, pio_write_n, pio_writedata}, {2'd2, 1'b0, 32'd1});
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_irq_dispatcher.md
Name: btn_irq_dispatcher

Overview:
- Services up to NUM_SRC button PIO slaves (edge-capture type, IRQ on falling edge) over one shared Avalon-MM master path.
- At start-up, writes irq_mask=1 into every PIO.
- Round-robin arbitrates pending IRQs, confirms each via an edge_capture read, clears it, and queues the source index in an event FIFO for the CPU-side consumer.

Parameters:
- NUM_SRC, 4, number of PIO sources (2..16).
- IDX_W, 2, source index width, = clog2(NUM_SRC).
- FIFO_DEPTH, 8, event FIFO entries (power of 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = service IRQs; 0 = hold in IDLE after INIT.
- src_irq  in  NUM_SRC  irq output of each PIO.
- pio_chipselect  out  NUM_SRC  one-hot select of the addressed PIO.
- pio_address  out  2  PIO register address (2 = irq_mask, 3 = edge_capture).
- pio_write_n  out  1  active-low write strobe.
- pio_writedata  out  32  write data.
- pio_readdata  in  NUM_SRC*32  readdata of each PIO; slice i belongs to source i; valid 1 cycle after address is presented.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
- evt_src  out  IDX_W  source index at FIFO head.
- evt_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- evt_overflow  out  1  sticky; set when an event is dropped; cleared only by reset.

Behaviour:
- Reset values: pio_chipselect=0, pio_address=0, pio_write_n=1, pio_writedata=0, evt_valid=0, evt_src=0, evt_count=0, evt_overflow=0. FSM=INIT, init index=0, rr pointer=0.
- All master outputs are registered. An idle bus is chipselect=0, write_n=1.
- INIT: one cycle per source i=0..NUM_SRC-1. Drive chipselect[i]=1, address=2, write_n=0, writedata=1. After i=NUM_SRC-1, go to IDLE. INIT runs regardless of enable.
- IDLE: if enable && |src_irq, grant the first asserted source at or after rr pointer, wrapping modulo NUM_SRC. Latch grant index g, set rr pointer=g+1 mod NUM_SRC, go to RD.
- RD: chipselect[g]=1, address=3, write_n=1. Go to RD_WAIT.
- RD_WAIT: sample pio_readdata slice g, bit 0.
  - If 0 (spurious): go to IDLE, no clear, no push.
  - Else: go to CLR.
- CLR: chipselect[g]=1, address=3, write_n=0, writedata=0. Go to PUSH.
- PUSH: push g into the FIFO. Go to IDLE.
  - If the FIFO is full and no pop occurs this cycle: drop the event, set evt_overflow=1.
- Latency: irq seen in IDLE at cycle t → RD t+1 → RD_WAIT t+2 → CLR t+3 → PUSH t+4 → evt_valid=1 at t+5 (empty FIFO).
- Stale-IRQ rule: the PIO irq drops the cycle after CLR. IDLE is first re-entered at t+5, so the same edge is never granted twice.
- An edge captured between RD and CLR is lost: the PIO gives clear priority over capture. This is accepted behaviour.
- enable deasserted mid-transaction: the current transaction completes; the next IDLE holds.
- reset asserted mid-operation: everything returns to reset values, the FIFO is emptied, and INIT reruns.
- FIFO:
  - Push and pop in the same cycle on a full FIFO: both take effect, no overflow.
  - Pop on empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_src shows the head entry combinationally from storage.

Decomposition:
- Shared package btn_irq_pkg holds:
  - state enum (INIT, IDLE, RD, RD_WAIT, CLR, PUSH);
  - PIO address constants (ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3).
- Sub-module btn_evt_fifo (synchronous FIFO, parameters WIDTH and DEPTH). It provides full, empty, count, push and pop ports.
- Arbiter and FSM live in the top level.

Test Plan:
- Reset release with enable=0, NUM_SRC=4 → 4 consecutive mask writes: chipselect 0001, 0010, 0100, 1000, address=2, writedata=1. Then bus idle, evt_valid=0.
- Single irq on src 2 at cycle t, readdata[2*32]=1 → RD at t+1, CLR write to address 3 with chipselect=0100 at t+3, evt_valid=1 and evt_src=2 at t+5.
- src_irq=1011 held, consumer always ready → grant order 0,1,3,0,1,3 (round robin wraps past idle src 2).
- FIFO_DEPTH=8, evt_ready=0, 9 confirmed events → evt_count=8, evt_overflow=1, ninth event dropped but still cleared. Then drain: first 8 indices emerge in order.
- irq asserted but edge_capture readback=0 → no CLR write, no push, FSM back in IDLE at t+3.
- reset pulse during CLR → outputs at reset values next cycle, FIFO empty, INIT mask writes repeat.
